countdown_display_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 25 ++
 rtl/countdown_display_driver_if.sv | 24 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/countdown_display_driver.sv | 127 ++++++++++++
 tb/tb_countdown_display_driver.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants and digit slot indices for the countdown display.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    // Active-high patterns in {g,f,e,d,c,b,a} order
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    localparam logic [IDX_W-1:0] DIGIT_SEC1  = 2'd0;
    localparam logic [IDX_W-1:0] DIGIT_SEC10 = 2'd1;
    localparam logic [IDX_W-1:0] DIGIT_MIN1  = 2'd2;
    localparam logic [IDX_W-1:0] DIGIT_MIN10 = 2'd3;

endpackage

// File: rtl/countdown_display_driver_if.sv
// Timer-to-display bundle: BCD digits and control in, multiplexed display lines out.
interface countdown_display_driver_if;

    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
    logic       clock_stopped;
    logic       blank_lead;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output sec_1s, sec_10s, min_1s, min_10s, clock_stopped, blank_lead,
        input  an, seg, dp
    );

    modport slave (
        input  sec_1s, sec_10s, min_1s, min_10s, clock_stopped, blank_lead,
        output an, seg, dp
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/countdown_display_driver.sv
// Scans the M:SS countdown onto a 4-digit multiplexed 7-segment display with
// frame snapshotting, leading-zero blanking and blinking once the timer stops.
module countdown_display_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned BLINK_DIV   = 50_000_000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    countdown_display_driver_if.slave  disp
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam bit          INV   = (ACTIVE_LOW != 0);

    logic [REF_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             first_slot;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic [3:0]       snap_sec_1s;
    logic [3:0]       snap_sec_10s;
    logic [3:0]       snap_min_1s;
    logic [3:0]       snap_min_10s;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             refresh_wrap_c;
    logic             blink_wrap_c;
    logic [3:0]       cur_digit_c;
    logic [6:0]       dec_seg_c;
    logic             lit_c;
    logic [3:0]       an_hi_c;
    logic [6:0]       seg_hi_c;
    logic             dp_hi_c;

    assign refresh_wrap_c = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
    assign blink_wrap_c   = (blink_cnt == BLK_W'(BLINK_DIV - 1));

    // Slot timing, digit advance and whole-frame snapshot
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            refresh_cnt  <= '0;
            digit_idx    <= '0;
            first_slot   <= 1'b1;
            snap_sec_1s  <= '0;
            snap_sec_10s <= '0;
            snap_min_1s  <= '0;
            snap_min_10s <= '0;
        end else if (refresh_wrap_c) begin
            refresh_cnt <= '0;
            first_slot  <= 1'b0;
            if (!first_slot) begin
                digit_idx <= digit_idx + IDX_W'(1);
            end
            if (first_slot || (digit_idx == DIGIT_MIN10)) begin
                snap_sec_1s  <= disp.sec_1s;
                snap_sec_10s <= disp.sec_10s;
                snap_min_1s  <= disp.min_1s;
                snap_min_10s <= disp.min_10s;
            end
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Blink phase runs only while stopped; otherwise parked at the start of an on-phase
    always_ff @(posedge clk_100MHz) begin
        if (reset || !disp.clock_stopped) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_wrap_c) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    always_comb begin
        cur_digit_c = snap_sec_1s;
        case (digit_idx)
            DIGIT_SEC1:  cur_digit_c = snap_sec_1s;
            DIGIT_SEC10: cur_digit_c = snap_sec_10s;
            DIGIT_MIN1:  cur_digit_c = snap_min_1s;
            DIGIT_MIN10: cur_digit_c = snap_min_10s;
            default:     cur_digit_c = snap_sec_1s;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd   (cur_digit_c),
        .seg_c (dec_seg_c)
    );

    // Active-high slot contents; stop release overrides blink phase without waiting a cycle
    always_comb begin
        lit_c = !first_slot
              && (!disp.clock_stopped || blink_on)
              && !(disp.blank_lead && (digit_idx == DIGIT_MIN10) && (snap_min_10s == 4'd0));
        an_hi_c  = lit_c ? (4'b0001 << digit_idx) : 4'b0000;
        seg_hi_c = lit_c ? dec_seg_c : 7'b0000000;
        dp_hi_c  = lit_c && (digit_idx == DIGIT_MIN1);
    end

    // Output register, the only place polarity is applied
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            an_q  <= INV ? 4'hF : 4'h0;
            seg_q <= INV ? 7'h7F : 7'h00;
            dp_q  <= INV;
        end else begin
            an_q  <= INV ? ~an_hi_c : an_hi_c;
            seg_q <= INV ? ~seg_hi_c : seg_hi_c;
            dp_q  <= INV ? ~dp_hi_c : dp_hi_c;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_countdown_display_driver.sv
// Directed bench for countdown_display_driver: frame table plus reset, tearing and blink sequences.
module tb_countdown_display_driver;

    logic clk_100MHz = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    countdown_display_driver_if dif ();

    countdown_display_driver #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (8),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .disp       (dif)
    );

    // Active-low expected segment patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] L0    = 7'b1000000;
    localparam logic [6:0] L1    = 7'b1111001;
    localparam logic [6:0] L2    = 7'b0100100;
    localparam logic [6:0] L3    = 7'b0110000;
    localparam logic [6:0] L4    = 7'b0011001;
    localparam logic [6:0] L5    = 7'b0010010;
    localparam logic [6:0] L8    = 7'b0000000;
    localparam logic [6:0] L9    = 7'b0010000;
    localparam logic [6:0] LDASH = 7'b0111111;
    localparam logic [6:0] DARK  = 7'b1111111;
    localparam logic [15:0] AN_ALL = 16'b0111_1011_1101_1110;
    localparam logic [15:0] AN_BL  = 16'b1111_1011_1101_1110;

    typedef struct packed {
        logic [15:0]     dig;
        logic            blank;
        logic [3:0][3:0] an_e;
        logic [3:0][6:0] seg_e;
        logic [3:0]      dp_e;
    } frame_t;

    function automatic frame_t mk(input logic [15:0] dig, input logic blank,
                                  input logic [15:0] an_e, input logic [27:0] seg_e,
                                  input logic [3:0] dp_e);
        frame_t f;
        f.dig   = dig;
        f.blank = blank;
        f.an_e  = an_e;
        f.seg_e = seg_e;
        f.dp_e  = dp_e;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_in(input logic [15:0] v);
        dif.min_10s = v[15:12];
        dif.min_1s  = v[11:8];
        dif.sec_10s = v[7:4];
        dif.sec_1s  = v[3:0];
    endtask

    task automatic chk(input string nm, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e);
        total++;
        if (dif.an !== an_e || dif.seg !== seg_e || dif.dp !== dp_e) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     nm, dif.an, dif.seg, dif.dp, an_e, seg_e, dp_e);
        end
    endtask

    task automatic chk_lit(input string nm);
        total++;
        if (dif.an === 4'hF || dif.seg !== L0) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%b, want lit digit 0", nm, dif.an, dif.seg);
        end
    endtask

    // Checks every cycle of one frame; nxt inputs applied at cycle 1 of slot chg_slot
    task automatic run_frame(input string nm, input frame_t f, input logic [15:0] nxt,
                             input int chg_slot);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("%s s%0d c%0d", nm, s, c), f.an_e[s], f.seg_e[s], f.dp_e[s]);
                if (s == 0 && c == 0) dif.blank_lead = f.blank;
                if (s == chg_slot && c == 1) set_in(nxt);
            end
        end
    endtask

    frame_t tbl [4];
    frame_t fr;
    logic [15:0] nxt;

    initial begin
        tbl[0] = mk(16'h0159, 1'b0, AN_ALL, {L0, L1, L5, L9}, 4'b1011);
        tbl[1] = mk(16'h0159, 1'b1, AN_BL,  {DARK, L1, L5, L9}, 4'b1011);
        tbl[2] = mk(16'h015C, 1'b0, AN_ALL, {L0, L1, L5, LDASH}, 4'b1011);
        tbl[3] = mk(16'h1234, 1'b1, AN_ALL, {L1, L2, L3, L4}, 4'b1011);

        reset             = 1'b1;
        dif.clock_stopped = 1'b0;
        dif.blank_lead    = 1'b0;
        set_in(tbl[0].dig);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset c%0d", i), 4'hF, DARK, 1'b1);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset dark c%0d", i), 4'hF, DARK, 1'b1);
        end

        for (int k = 0; k < 4; k++) begin
            nxt = (k < 3) ? tbl[k+1].dig : 16'h0159;
            run_frame($sformatf("frame%0d", k), tbl[k], nxt, 0);
        end

        // Mid-frame change must not tear the displayed frame
        run_frame("tear_old", tbl[0], 16'h0158, 1);
        fr = mk(16'h0158, 1'b0, AN_ALL, {L0, L1, L5, L8}, 4'b1011);
        run_frame("tear_new", fr, 16'h0000, 0);

        // Stop with 0:00: 8 on, 8 off, repeating; drop during the dark phase
        dif.clock_stopped = 1'b1;
        for (int i = 0; i < 28; i++) begin
            tick();
            if (((i / 8) % 2) == 1) chk($sformatf("blink dark c%0d", i), 4'hF, DARK, 1'b1);
            else                    chk_lit($sformatf("blink on c%0d", i));
        end
        dif.clock_stopped = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            chk_lit($sformatf("unstopped c%0d", i));
        end

        // Reset mid-scan: one dark slot, then idx0 again
        tick();
        reset = 1'b1;
        tick();
        chk("midscan reset", 4'hF, DARK, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midscan dark c%0d", i), 4'hF, DARK, 1'b1);
        end
        tick();
        chk("midscan idx0", 4'b1110, L0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
